// File: rtl/dnn_argmax_collector.sv
// ---------------------------------------------------------------------------
// dnn_argmax_collector
//
// Purpose:
//   Captures the final DNN layer's output vector and finds the class with the
//   largest neuron value. The search is a serial compare, one lane per cycle.
//   The winning index and value are held on a valid/ready output until the
//   consumer accepts them. The block also counts accepted results and keeps
//   a sticky flag for vectors that upstream offered while it was busy.
//
// Configuration:
//   ARGMAX_SIGNED_EN - when defined, lanes are compared as two's-complement
//                      signed values. When undefined (default), the compare
//                      is unsigned.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   res_n       in   synchronous active-low reset
//   in_valid    in   upstream vector valid
//   in_data     in   [NumOut-1:0][BitSize-1:0] neuron outputs, lane i = neuron i
//   in_done     in   upstream end-of-image pulse (does not affect the result)
//   in_ready    out  block can capture a vector this cycle (state == IDLE)
//   class_valid out  result valid, held until class_ready
//   class_ready in   consumer accepts the result
//   class_idx   out  index of the maximum lane (lowest index on ties)
//   class_value out  value of the maximum lane
//   frame_count out  results accepted by the consumer, wraps modulo 2^CountW
//   overrun     out  sticky: in_valid was seen while in_ready was low
// ---------------------------------------------------------------------------
module dnn_argmax_collector #(
  parameter int BitSize = 4,
  parameter int NumOut  = 2,
  parameter int IdxW    = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter int CountW  = 8
) (
  input  logic                             clk,
  input  logic                             res_n,
  input  logic                             in_valid,
  input  logic [NumOut-1:0][BitSize-1:0]   in_data,
  input  logic                             in_done,
  output logic                             in_ready,
  output logic                             class_valid,
  input  logic                             class_ready,
  output logic [IdxW-1:0]                  class_idx,
  output logic [BitSize-1:0]               class_value,
  output logic [CountW-1:0]                frame_count,
  output logic                             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [IdxW-1:0] LastLane = IdxW'(NumOut - 1);

  state_t                         state_q;
  logic [NumOut-1:0][BitSize-1:0] vec_q;
  logic [IdxW-1:0]                scan_q;
  logic [IdxW-1:0]                best_idx_q;
  logic [BitSize-1:0]             best_val_q;
  logic                           class_valid_q;
  logic [CountW-1:0]              frame_count_q;
  logic                           overrun_q;

  logic [BitSize-1:0]             lane_d;
  logic                           take_d;

  // in_done has no effect on the result path: a vector is processed whether
  // or not it coincides with end-of-image, and a scan is never aborted.
  logic                           unused_in_done;
  assign unused_in_done = in_done;

  // Strict greater-than, so ties keep the earlier (lower) index.
  function automatic logic lane_gt(input logic [BitSize-1:0] a,
                                   input logic [BitSize-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Lane selection by loop so a scan index outside 0..NumOut-1 (possible when
  // NumOut is not a power of two, or NumOut==1) never produces a bad select.
  always_comb begin
    lane_d = '0;
    for (int i = 0; i < NumOut; i++) begin
      if (scan_q == IdxW'(i)) begin
        lane_d = vec_q[i];
      end
    end
    take_d = lane_gt(lane_d, best_val_q);
  end

  assign in_ready    = (state_q == IDLE);
  assign class_valid = class_valid_q;
  assign class_idx   = best_idx_q;
  assign class_value = best_val_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q       <= IDLE;
      vec_q         <= '0;
      scan_q        <= '0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
      class_valid_q <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      // Any vector offered while busy is dropped and flagged.
      if (in_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q      <= in_data;
            best_val_q <= in_data[0];
            best_idx_q <= '0;
            scan_q     <= IdxW'(1);
            if (NumOut > 1) begin
              state_q <= SCAN;
            end else begin
              state_q       <= HOLD;
              class_valid_q <= 1'b1;
            end
          end
        end

        SCAN: begin
          if (take_d) begin
            best_val_q <= lane_d;
            best_idx_q <= scan_q;
          end
          if (scan_q == LastLane) begin
            state_q       <= HOLD;
            class_valid_q <= 1'b1;
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end

        HOLD: begin
          if (class_ready) begin
            class_valid_q <= 1'b0;
            frame_count_q <= frame_count_q + 1'b1;
            state_q       <= IDLE;
          end
        end

        default: begin
          state_q       <= IDLE;
          class_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_argmax_collector.sv
// ---------------------------------------------------------------------------
// tb_dnn_argmax_collector
//
// Two instances share clock and reset:
//   d2 : NumOut=2, CountW=8  (basic, signedness, backpressure/overrun)
//   d4 : NumOut=4, CountW=2  (reset mid-scan, tie/scan order, counter wrap,
//                             accept-while-offered)
// Expected values are hand-computed; the signed build selects its own column.
// ---------------------------------------------------------------------------
module tb_dnn_argmax_collector;

  logic clk;
  logic res_n;

  logic             in_valid2, in_done2, class_ready2;
  logic [1:0][3:0]  in_data2;
  logic             in_ready2, class_valid2, overrun2;
  logic [0:0]       class_idx2;
  logic [3:0]       class_value2;
  logic [7:0]       frame_count2;

  logic             in_valid4, in_done4, class_ready4;
  logic [3:0][3:0]  in_data4;
  logic             in_ready4, class_valid4, overrun4;
  logic [1:0]       class_idx4;
  logic [3:0]       class_value4;
  logic [1:0]       frame_count4;

  int checks = 0;
  int errors = 0;
  int fc2 = 0;
  int fc4 = 0;

  dnn_argmax_collector #(.BitSize(4), .NumOut(2), .CountW(8)) d2 (
    .clk(clk), .res_n(res_n),
    .in_valid(in_valid2), .in_data(in_data2), .in_done(in_done2),
    .in_ready(in_ready2), .class_valid(class_valid2), .class_ready(class_ready2),
    .class_idx(class_idx2), .class_value(class_value2),
    .frame_count(frame_count2), .overrun(overrun2)
  );

  dnn_argmax_collector #(.BitSize(4), .NumOut(4), .CountW(2)) d4 (
    .clk(clk), .res_n(res_n),
    .in_valid(in_valid4), .in_data(in_data4), .in_done(in_done4),
    .in_ready(in_ready4), .class_valid(class_valid4), .class_ready(class_ready4),
    .class_idx(class_idx4), .class_value(class_value4),
    .frame_count(frame_count4), .overrun(overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;   // 2 or 4: which instance
    logic [3:0] l0, l1, l2, l3;
    logic       done;
    int         idx;
    int         val;
  } vec_t;

  vec_t tbl[10];
  int   ntbl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cv(input int sel);
    return (sel == 4) ? int'(class_valid4) : int'(class_valid2);
  endfunction
  function automatic int rdy(input int sel);
    return (sel == 4) ? int'(in_ready4) : int'(in_ready2);
  endfunction
  function automatic int cidx(input int sel);
    return (sel == 4) ? int'(class_idx4) : int'(class_idx2);
  endfunction
  function automatic int cval(input int sel);
    return (sel == 4) ? int'(class_value4) : int'(class_value2);
  endfunction
  function automatic int fcnt(input int sel);
    return (sel == 4) ? int'(frame_count4) : int'(frame_count2);
  endfunction

  // Wait (bounded) for class_valid; returns edges after the capture edge.
  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (cv(sel) == 0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", rdy(v.sel), 1);
    if (v.sel == 4) begin
      in_valid4 = 1'b1; in_data4 = {v.l3, v.l2, v.l1, v.l0}; in_done4 = v.done;
    end else begin
      in_valid2 = 1'b1; in_data2 = {v.l1, v.l0}; in_done2 = v.done;
    end
    @(negedge clk);  // capture edge has passed
    in_valid4 = 1'b0; in_done4 = 1'b0;
    in_valid2 = 1'b0; in_done2 = 1'b0;
    wait_valid(v.sel, lat);
    chk("latency", lat, v.sel - 1);
    chk("class_idx", cidx(v.sel), v.idx);
    chk("class_value", cval(v.sel), v.val);
    chk("in_ready_hold", rdy(v.sel), 0);
    if (v.sel == 4) class_ready4 = 1'b1; else class_ready2 = 1'b1;
    @(negedge clk);
    class_ready4 = 1'b0; class_ready2 = 1'b0;
    if (v.sel == 4) begin
      fc4++;
      chk("frame_count4", fcnt(4), fc4 % 4);
    end else begin
      fc2++;
      chk("frame_count2", fcnt(2), fc2 % 256);
    end
    chk("valid_drop", cv(v.sel), 0);
  endtask

  initial begin
    int lat;
    logic [3:0] hold_val;
    int hold_idx;

    // Table (lane values hand-picked; signed column where a lane has bit 3 set).
    tbl[0] = '{2, 4'd5, 4'd3, 4'd0, 4'd0, 1'b0, 0, 5};   // basic: lane0=5 lane1=3
`ifdef ARGMAX_SIGNED_EN
    tbl[1] = '{2, 4'd7, 4'd8, 4'd0, 4'd0, 1'b0, 0, 7};   // 8 is -8
`else
    tbl[1] = '{2, 4'd7, 4'd8, 4'd0, 4'd0, 1'b0, 1, 8};
`endif
    tbl[2] = '{2, 4'd2, 4'd6, 4'd0, 4'd0, 1'b1, 1, 6};   // in_done with capture
`ifdef ARGMAX_SIGNED_EN
    tbl[3] = '{4, 4'd2, 4'd9, 4'd9, 4'd1, 1'b0, 0, 2};   // 9 is -7
`else
    tbl[3] = '{4, 4'd2, 4'd9, 4'd9, 4'd1, 1'b0, 1, 9};   // tie keeps lane 1
`endif
    tbl[4] = '{4, 4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 0, 7};   // all equal
    tbl[5] = '{4, 4'd1, 4'd2, 4'd3, 4'd6, 1'b0, 3, 6};   // last lane wins
    tbl[6] = '{4, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0};
    tbl[7] = '{4, 4'd3, 4'd5, 4'd5, 4'd4, 1'b1, 1, 5};
`ifdef ARGMAX_SIGNED_EN
    tbl[8] = '{4, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 1, 0}; // 15 is -1
`else
    tbl[8] = '{4, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 0, 15};
`endif
    tbl[9] = '{4, 4'd4, 4'd6, 4'd2, 4'd5, 1'b0, 1, 6};
    ntbl = 10;

    res_n = 1'b0;
    in_valid2 = 0; in_done2 = 0; class_ready2 = 0; in_data2 = '0;
    in_valid4 = 0; in_done4 = 0; class_ready4 = 0; in_data4 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid2", int'(class_valid2), 0);
    chk("rst_idx2", int'(class_idx2), 0);
    chk("rst_value2", int'(class_value2), 0);
    chk("rst_fc2", int'(frame_count2), 0);
    chk("rst_overrun2", int'(overrun2), 0);
    chk("rst_ready2", int'(in_ready2), 1);
    chk("rst_valid4", int'(class_valid4), 0);
    chk("rst_fc4", int'(frame_count4), 0);
    chk("rst_ready4", int'(in_ready4), 1);
    res_n = 1'b1;

    // Reset mid-scan abandons the vector
    @(negedge clk);
    in_valid4 = 1'b1; in_data4 = {4'd4, 4'd3, 4'd2, 4'd1};
    @(negedge clk);
    in_valid4 = 1'b0;
    chk("scan_busy_ready4", int'(in_ready4), 0);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    chk("midscan_valid4", int'(class_valid4), 0);
    chk("midscan_fc4", int'(frame_count4), 0);
    chk("midscan_ready4", int'(in_ready4), 1);
    wait_valid(4, lat);
    chk("midscan_no_result", lat, 20);

    // in_done alone in IDLE is ignored
    @(negedge clk);
    in_done4 = 1'b1;
    @(negedge clk);
    in_done4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_only_valid4", int'(class_valid4), 0);
    chk("done_only_ready4", int'(in_ready4), 1);

    // Table-driven vectors (d4 part also walks frame_count 1,2,3,0,1,2,3)
    for (int i = 0; i < ntbl; i++) run_vec(tbl[i]);

    // Backpressure on d2, with a dropped vector offered during the hold
    @(negedge clk);
    in_valid2 = 1'b1; in_data2 = {4'd10, 4'd3};
    @(negedge clk);
    in_valid2 = 1'b0;
    wait_valid(2, lat);
    chk("bp_latency", lat, 1);
`ifdef ARGMAX_SIGNED_EN
    hold_idx = 0; hold_val = 4'd3;
`else
    hold_idx = 1; hold_val = 4'd10;
`endif
    chk("bp_overrun_before", int'(overrun2), 0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", int'(class_valid2), 1);
      chk("bp_idx", int'(class_idx2), hold_idx);
      chk("bp_value", int'(class_value2), int'(hold_val));
      chk("bp_ready", int'(in_ready2), 0);
      if (c == 2) begin
        in_valid2 = 1'b1; in_data2 = {4'd15, 4'd15};
      end else begin
        in_valid2 = 1'b0;
      end
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    chk("bp_overrun_set", int'(overrun2), 1);
    chk("bp_idx_after", int'(class_idx2), hold_idx);
    chk("bp_value_after", int'(class_value2), int'(hold_val));
    class_ready2 = 1'b1;
    @(negedge clk);
    class_ready2 = 1'b0;
    fc2++;
    chk("bp_fc2", int'(frame_count2), fc2);
    wait_valid(2, lat);
    chk("bp_dropped_never_reported", lat, 20);
    chk("bp_overrun_sticky", int'(overrun2), 1);

    // Accept and offer in the same HOLD cycle on d4
    @(negedge clk);
    in_valid4 = 1'b1; in_data4 = {4'd1, 4'd1, 4'd1, 4'd1};
    @(negedge clk);
    in_valid4 = 1'b0;
    wait_valid(4, lat);
    chk("sim_latency", lat, 3);
    chk("sim_overrun_before", int'(overrun4), 0);
    class_ready4 = 1'b1; in_valid4 = 1'b1; in_data4 = {4'd9, 4'd9, 4'd9, 4'd9};
    @(negedge clk);
    class_ready4 = 1'b0; in_valid4 = 1'b0;
    fc4++;
    chk("sim_overrun_set", int'(overrun4), 1);
    chk("sim_fc4", int'(frame_count4), fc4 % 4);
    chk("sim_valid_drop", int'(class_valid4), 0);
    chk("sim_ready", int'(in_ready4), 1);
    wait_valid(4, lat);
    chk("sim_not_captured", lat, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
